// File: rtl/hazard_unit_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_unit_pkg;

  localparam int REG_SRC_LENGTH = 2;
  localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_MEM = 2'b01;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // A write to $0 is architecturally discarded, so it never produces a dependency.
  function automatic logic reg_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_md_busy_fsm.sv
// Mul/div occupancy tracker: busy for MD_LATENCY-1 cycles after a start, then a done pulse.
module md_busy_fsm
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  md_state_t     state;
  logic [CW-1:0] md_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            state  <= MD_BUSY;
            md_cnt <= CW'(MD_LATENCY - 2);
            busy   <= 1'b1;
          end
        end
        MD_BUSY: begin
          // A start while busy is ignored; upstream stalling should prevent it.
          if (md_cnt == '0) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            md_cnt <= md_cnt - CW'(1);
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, stall/flush generation,
// mul/div busy sequencing and saturating stall/flush performance counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                rsD,
  input  logic [4:0]                rtD,
  input  logic [4:0]                rsE,
  input  logic [4:0]                rtE,
  input  logic [4:0]                writeRegE,
  input  logic [4:0]                writeRegM,
  input  logic [4:0]                writeRegW,
  input  logic                      Regfile_weE,
  input  logic                      Regfile_weM,
  input  logic                      Regfile_weW,
  input  logic [REG_SRC_LENGTH-1:0] regSrc_muxE,
  input  logic [REG_SRC_LENGTH-1:0] regSrc_muxM,
  input  logic                      branchD,
  input  logic                      pcSrcD,
  input  logic                      mdStartE,
  input  logic                      mdUseD,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      flushD,
  output logic                      flushE,
  output logic [1:0]                forwardAE,
  output logic [1:0]                forwardBE,
  output logic                      forwardAD,
  output logic                      forwardBD,
  output logic                      mdBusy,
  output logic                      mdDone,
  output logic [CNT_W-1:0]          stallCnt,
  output logic [CNT_W-1:0]          flushCnt
);

  logic lw_stall, br_stall, md_stall, stall;
  logic load_e, load_m;

  // MEM result is newer than WB, so it wins when both match.
  always_comb begin
    forwardAE = FWD_REG;
    if (reg_hit(Regfile_weM, writeRegM, rsE))      forwardAE = FWD_MEM;
    else if (reg_hit(Regfile_weW, writeRegW, rsE)) forwardAE = FWD_WB;
    forwardBE = FWD_REG;
    if (reg_hit(Regfile_weM, writeRegM, rtE))      forwardBE = FWD_MEM;
    else if (reg_hit(Regfile_weW, writeRegW, rtE)) forwardBE = FWD_WB;
  end

  assign forwardAD = reg_hit(Regfile_weM, writeRegM, rsD);
  assign forwardBD = reg_hit(Regfile_weM, writeRegM, rtD);

  assign load_e   = (regSrc_muxE == REG_SRC_MEM);
  assign load_m   = (regSrc_muxM == REG_SRC_MEM);
  assign lw_stall = reg_hit(load_e, writeRegE, rsD) || reg_hit(load_e, writeRegE, rtD);
  // Branches compare in ID, so an ALU result still in EX or a load in MEM is too late.
  assign br_stall = branchD &&
                    (reg_hit(Regfile_weE, writeRegE, rsD) || reg_hit(Regfile_weE, writeRegE, rtD) ||
                     reg_hit(load_m, writeRegM, rsD)      || reg_hit(load_m, writeRegM, rtD));
  assign md_stall = mdUseD && (mdBusy || mdStartE);
  assign stall    = lw_stall || br_stall || md_stall;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = pcSrcD && !stall;

  md_busy_fsm #(.MD_LATENCY(MD_LATENCY)) u_md_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (mdStartE),
    .busy  (mdBusy),
    .done  (mdDone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall && (stallCnt != '1))  stallCnt <= stallCnt + CNT_W'(1);
      if (flushD && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use, branch, mul/div busy,
// async reset mid-operation and counter saturation on a narrow-counter instance.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic Regfile_weE, Regfile_weM, Regfile_weW;
  logic [1:0] regSrc_muxE, regSrc_muxM;
  logic branchD, pcSrcD, mdStartE, mdUseD;

  logic stallF, stallD, flushD, flushE, forwardAD, forwardBD, mdBusy, mdDone;
  logic [1:0] forwardAE, forwardBE;
  logic [31:0] stallCnt, flushCnt;

  logic s_stallF, s_stallD, s_flushD, s_flushE, s_forwardAD, s_forwardBD, s_mdBusy, s_mdDone;
  logic [1:0] s_forwardAE, s_forwardBE;
  logic [3:0] s_stallCnt, s_flushCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MD_LATENCY(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW),
    .regSrc_muxE(regSrc_muxE), .regSrc_muxM(regSrc_muxM), .branchD(branchD),
    .pcSrcD(pcSrcD), .mdStartE(mdStartE), .mdUseD(mdUseD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD),
    .forwardBD(forwardBD), .mdBusy(mdBusy), .mdDone(mdDone),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  hazard_unit #(.MD_LATENCY(8), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW),
    .regSrc_muxE(regSrc_muxE), .regSrc_muxM(regSrc_muxM), .branchD(branchD),
    .pcSrcD(pcSrcD), .mdStartE(mdStartE), .mdUseD(mdUseD),
    .stallF(s_stallF), .stallD(s_stallD), .flushD(s_flushD), .flushE(s_flushE),
    .forwardAE(s_forwardAE), .forwardBE(s_forwardBE), .forwardAD(s_forwardAD),
    .forwardBD(s_forwardBD), .mdBusy(s_mdBusy), .mdDone(s_mdDone),
    .stallCnt(s_stallCnt), .flushCnt(s_flushCnt)
  );

  task automatic idle_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeRegE = 0; writeRegM = 0; writeRegW = 0;
    Regfile_weE = 0; Regfile_weM = 0; Regfile_weW = 0;
    regSrc_muxE = 2'b00; regSrc_muxM = 2'b00;
    branchD = 0; pcSrcD = 0; mdStartE = 0; mdUseD = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++; if ({stallF, stallD, flushD, flushE, mdBusy, mdDone} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl got=%b exp=000000", {stallF, stallD, flushD, flushE, mdBusy, mdDone}); end
    checks++; if (stallCnt !== 32'd0 || flushCnt !== 32'd0) begin errors++;
      $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0/0", stallCnt, flushCnt); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_forward();
    Regfile_weM = 1; writeRegM = 3; rsE = 3; rtE = 7; #1;
    checks++; if (forwardAE !== 2'b10) begin errors++;
      $display("FAIL fwd_mem_a got=%b exp=10", forwardAE); end
    checks++; if (forwardBE !== 2'b00) begin errors++;
      $display("FAIL fwd_none_b got=%b exp=00", forwardBE); end
    Regfile_weM = 0; Regfile_weW = 1; writeRegW = 3; #1;
    checks++; if (forwardAE !== 2'b01) begin errors++;
      $display("FAIL fwd_wb_a got=%b exp=01", forwardAE); end
    Regfile_weM = 1; writeRegM = 7; writeRegW = 7; rsE = 9; #1;
    checks++; if (forwardBE !== 2'b10) begin errors++;
      $display("FAIL fwd_prio_b got=%b exp=10", forwardBE); end
    writeRegM = 0; writeRegW = 0; rsE = 0; rtE = 0; #1;
    checks++; if (forwardAE !== 2'b00 || forwardBE !== 2'b00) begin errors++;
      $display("FAIL fwd_r0 got A=%b B=%b exp 00/00", forwardAE, forwardBE); end
    rsD = 0; #1;
    checks++; if (forwardAD !== 1'b0) begin errors++;
      $display("FAIL fwd_ad_r0 got=%b exp=0", forwardAD); end
    idle_inputs(); #1;
    $display("test_forward done");
  endtask

  task automatic test_load_use();
    regSrc_muxE = 2'b01; writeRegE = 2; rtD = 2; pcSrcD = 1; #1;
    checks++; if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin errors++;
      $display("FAIL lw_stall got=%b exp=1110", {stallF, stallD, flushE, flushD}); end
    tick();
    idle_inputs(); #1;
    checks++; if (stallF !== 1'b0) begin errors++;
      $display("FAIL lw_release got=%b exp=0", stallF); end
    checks++; if (stallCnt !== 32'd1 || flushCnt !== 32'd0) begin errors++;
      $display("FAIL lw_cnt got stall=%0d flush=%0d exp 1/0", stallCnt, flushCnt); end
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    branchD = 1; rsD = 4; rtD = 6; Regfile_weE = 1; writeRegE = 4; pcSrcD = 1; #1;
    checks++; if ({stallF, flushD} !== 2'b10) begin errors++;
      $display("FAIL br_ex_stall got=%b exp=10", {stallF, flushD}); end
    tick();
    Regfile_weE = 0; writeRegE = 0; Regfile_weM = 1; writeRegM = 4; #1;
    checks++; if ({stallF, forwardAD, forwardBD, flushD} !== 4'b0101) begin errors++;
      $display("FAIL br_fwd got=%b exp=0101", {stallF, forwardAD, forwardBD, flushD}); end
    tick();
    checks++; if (stallCnt !== 32'd2 || flushCnt !== 32'd1) begin errors++;
      $display("FAIL br_cnt got stall=%0d flush=%0d exp 2/1", stallCnt, flushCnt); end
    idle_inputs();
    branchD = 1; rtD = 5; regSrc_muxM = 2'b01; writeRegM = 5; #1;
    checks++; if (stallD !== 1'b1) begin errors++;
      $display("FAIL br_load_mem got=%b exp=1", stallD); end
    tick();
    idle_inputs(); #1;
    checks++; if (stallCnt !== 32'd3) begin errors++;
      $display("FAIL br_cnt2 got=%0d exp=3", stallCnt); end
    $display("test_branch done");
  endtask

  task automatic test_muldiv();
    mdStartE = 1; #1;
    checks++; if (mdBusy !== 1'b0 || stallF !== 1'b0) begin errors++;
      $display("FAIL md_start got busy=%b stall=%b exp 0/0", mdBusy, stallF); end
    tick();
    mdStartE = 0; mdUseD = 1;
    for (int i = 1; i <= 7; i++) begin
      #1;
      checks++; if ({mdBusy, mdDone, stallF} !== 3'b101) begin errors++;
        $display("FAIL md_busy_t%0d got=%b exp=101", i, {mdBusy, mdDone, stallF}); end
      tick();
    end
    #1;
    checks++; if ({mdBusy, mdDone, stallF} !== 3'b010) begin errors++;
      $display("FAIL md_done got=%b exp=010", {mdBusy, mdDone, stallF}); end
    mdUseD = 0;
    tick();
    checks++; if (mdDone !== 1'b0) begin errors++;
      $display("FAIL md_done_pulse got=%b exp=0", mdDone); end
    checks++; if (stallCnt !== 32'd10) begin errors++;
      $display("FAIL md_cnt got=%0d exp=10", stallCnt); end
    $display("test_muldiv done");
  endtask

  task automatic test_reset_midbusy();
    int done_seen;
    done_seen = 0;
    mdStartE = 1;
    tick();
    mdStartE = 0;
    tick(); tick();
    checks++; if (mdBusy !== 1'b1) begin errors++;
      $display("FAIL rst_pre_busy got=%b exp=1", mdBusy); end
    #2 rst = 1'b1; #1;
    checks++; if (mdBusy !== 1'b0 || stallCnt !== 32'd0 || flushCnt !== 32'd0) begin errors++;
      $display("FAIL rst_async got busy=%b stall=%0d flush=%0d exp 0/0/0", mdBusy, stallCnt, flushCnt); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mdDone === 1'b1 || mdBusy === 1'b1) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin errors++;
      $display("FAIL rst_no_done got=%0d active cycles exp=0", done_seen); end
    $display("test_reset_midbusy done");
  endtask

  task automatic test_saturate();
    regSrc_muxE = 2'b01; writeRegE = 2; rtD = 2; pcSrcD = 1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (s_stallCnt !== 4'hF) begin errors++;
      $display("FAIL sat_15 got=%h exp=f", s_stallCnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (s_stallCnt !== 4'hF || stallCnt !== 32'd20) begin errors++;
      $display("FAIL sat_20 got small=%h wide=%0d exp f/20", s_stallCnt, stallCnt); end
    checks++; if (s_flushCnt !== 4'h0) begin errors++;
      $display("FAIL sat_flush got=%h exp=0", s_flushCnt); end
    idle_inputs();
    pcSrcD = 1;
    for (int i = 0; i < 17; i++) tick();
    checks++; if (s_flushCnt !== 4'hF || flushCnt !== 32'd17) begin errors++;
      $display("FAIL sat_flush17 got small=%h wide=%0d exp f/17", s_flushCnt, flushCnt); end
    idle_inputs();
    $display("test_saturate done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_muldiv();
    test_reset_midbusy();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
